// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes and bounce direction.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// Prescaler: free-running up-counter that pulses tick when it reaches div, then clears.
module tick_divider #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // div is sampled live; a div lowered below the count simply lets the counter roll over.
    assign tick = en & ~clr & (cnt_q == div);

    // Next count: clear wins, then terminal count, then increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left, rotate-right, bounce and binary count patterns,
// advanced once per prescaler tick, with registered step/wrap pulses.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             load,
    output logic [WIDTH-1:0] po_a,
    output logic             step,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] PAT_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PAT_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    logic             tick;
    logic [WIDTH-1:0] po_q, po_d;
    mode_t            mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .div   (div),
        .tick  (tick)
    );

    // Next pattern state: load re-initialises and suppresses the tick; otherwise a tick advances.
    always_comb begin
        po_d   = po_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            mode_d = mode_t'(mode);
            dir_d  = DIR_UP;
            po_d   = (mode_t'(mode) == MODE_COUNT) ? '0 : PAT_LSB;
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_ROT_L: begin
                    po_d   = {po_q[WIDTH-2:0], po_q[WIDTH-1]};
                    wrap_d = (po_d == PAT_LSB);
                end
                MODE_ROT_R: begin
                    po_d   = {po_q[0], po_q[WIDTH-1:1]};
                    wrap_d = (po_d == PAT_MSB);
                end
                MODE_BOUNCE: begin
                    // Direction flips on the step that lands on an end, so the end value never repeats.
                    if (dir_q == DIR_UP) begin
                        po_d = po_q << 1;
                        if (po_d[WIDTH-1]) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        po_d = po_q >> 1;
                        if (po_d[0]) begin
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end
                    end
                end
                MODE_COUNT: begin
                    po_d   = po_q + 1'b1;
                    wrap_d = (po_d == '0);
                end
                default: begin
                    po_d = po_q;
                end
            endcase
        end
    end

    // Pattern, mode, direction and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            po_q   <= PAT_LSB;
            mode_q <= MODE_ROT_L;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            po_q   <= po_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign po_a = po_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: pattern width, legal range 2..32.
REQ-002 The block SHALL have parameter DIV_W, default 24: prescaler divisor width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: run enable; 0 freezes the prescaler and the pattern.
REQ-006 The block SHALL have port div, input, DIV_W bits: step period minus 1, in clk cycles; sampled live.
REQ-007 The block SHALL have port mode, input, 2 bits: requested mode; captured only on load.
REQ-008 The block SHALL have port load, input, 1 bit: single-cycle pulse that latches mode and re-initialises the pattern.
REQ-009 The block SHALL have port po_a, output, WIDTH bits: registered pattern output.
REQ-010 The block SHALL have port step, output, 1 bit: registered pulse, high for the cycle in which po_a shows a newly advanced value.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered pulse, high for the cycle in which po_a shows the start-of-sequence value after advancing.

Function
REQ-012 Prescaler: the counter SHALL increment while en=1; when counter==div it SHALL assert an internal tick and clear to 0. With div=0, a tick SHALL occur every enabled cycle.
REQ-013 If div is lowered below the current count, the counter SHALL continue counting, wrap through 2^DIV_W and clear, with no special handling.
REQ-014 On a tick with no load, po_a SHALL advance one step per the latched mode, and step SHALL be 1 in the following cycle.
REQ-015 Mode 00 (ROT_L) SHALL advance as po_a <= {po_a[WIDTH-2:0], po_a[WIDTH-1]}; wrap SHALL be asserted when the new value is 1.
REQ-016 Mode 01 (ROT_R) SHALL advance as po_a <= {po_a[0], po_a[WIDTH-1:1]}; wrap SHALL be asserted when the new value has only the MSB set.
REQ-017 Mode 10 (BOUNCE): a direction state SHALL take the values UP or DOWN.
REQ-018 In BOUNCE/UP, po_a SHALL shift left; on reaching the MSB it SHALL switch to DOWN.
REQ-019 In BOUNCE/DOWN, po_a SHALL shift right; on reaching the LSB it SHALL switch to UP and assert wrap.
REQ-020 In BOUNCE, the end one-hot value SHALL NOT repeat on consecutive steps.
REQ-021 Mode 11 (COUNT): po_a SHALL be a binary up-counter mod 2^WIDTH; wrap SHALL be asserted when the new value is 0.
REQ-022 On load=1, the block SHALL latch mode, clear the prescaler, set direction UP, and set po_a to 0 in COUNT or 1 in the other modes; step and wrap SHALL be 0 in the next cycle.
REQ-023 load SHALL take effect regardless of en.
REQ-024 load SHALL win over a simultaneous tick: no advance occurs, and no step is produced in that cycle.
REQ-025 When en=0 without load, po_a, the prescaler, the direction state and the latched mode SHALL all hold, and step and wrap SHALL be 0.
REQ-026 step and wrap SHALL never be asserted in consecutive cycles unless div=0.

Reset
REQ-027 On reset=1, the block SHALL set po_a=1, prescaler=0, latched mode=00, direction=UP, step=0 and wrap=0 on the next edge.
REQ-028 reset SHALL override load, en and tick.
REQ-029 Reset asserted mid-sequence SHALL restart the ROT_L sequence from 1 after release.

Structure
REQ-030 A shared package led_pattern_pkg SHALL hold the mode encodings (MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE, MODE_COUNT) and the direction encodings (DIR_UP, DIR_DOWN).
REQ-031 The prescaler SHALL be a sub-module tick_divider (parameter DIV_W; ports clk, reset, en, clr, div, tick).
REQ-032 Pattern/FSM logic SHALL remain in led_pattern_gen.

Verification (WIDTH=8)
REQ-033 Reset, en=1, div=0, mode 00: po_a SHALL go 01,02,04,...,80,01; wrap SHALL be high only on the 01 cycle, with the first wrap after 8 steps.
REQ-034 div=3: step SHALL pulse every 4th cycle; po_a SHALL change only in step cycles.
REQ-035 load with mode=10: po_a SHALL go 01,02,...,80,40,...,01,02, with wrap on each return to 01 and no duplicated 80 or 01.
REQ-036 load with mode=11, div=0: po_a SHALL go 00,01,...,FF,00, with wrap on 00 after 256 steps.
REQ-037 load coincident with a tick in mode 00 at po_a=08, switching to mode 01: next po_a SHALL be 01, step=0; the next tick SHALL give 80 with wrap=1.
REQ-038 en=0 for 10 cycles mid-run: po_a SHALL be frozen with no pulses and SHALL resume in exact sequence afterward; reset mid-run in BOUNCE/DOWN SHALL give po_a=01, ROT_L.
